// File: rtl/branch_commit.sv
//==============================================================================
// Module      : branch_commit
// Description : Circular FIFO of in-flight predicted branches. Entries are
//               allocated at dispatch, resolved out of order by execution and
//               retired in order; each retirement emits a one-cycle BHT
//               update pulse telling whether the prediction was right.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module branch_commit #(
    parameter int DEPTH = 16,
    parameter int TAG_W = 4,
    parameter int BHT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rdy,
    input  logic             Clear_flag,
    input  logic             alloc_valid,
    input  logic [BHT_W-1:0] alloc_bht_id,
    input  logic             alloc_pred,
    output logic             alloc_ready,
    output logic [TAG_W-1:0] alloc_tag,
    input  logic             res_valid,
    input  logic [TAG_W-1:0] res_tag,
    input  logic             res_taken,
    input  logic             commit_valid,
    output logic             commit_ready,
    output logic             ROB_to_BHT_needchange,
    output logic             ROB_to_BHT_needchange2,
    output logic [BHT_W-1:0] bht_id2,
    output logic             mispredict,
    output logic [TAG_W:0]   count
);

    // Entry lifecycle encoding
    localparam logic [1:0] ST_FREE     = 2'd0;
    localparam logic [1:0] ST_PENDING  = 2'd1;
    localparam logic [1:0] ST_RESOLVED = 2'd2;

    localparam logic [TAG_W:0] FULL_CNT = DEPTH[TAG_W:0];

    logic [BHT_W-1:0] ent_id    [DEPTH];
    logic             ent_pred  [DEPTH];
    logic             ent_taken [DEPTH];
    logic [1:0]       ent_state [DEPTH];

    logic [TAG_W-1:0] head;
    logic [TAG_W-1:0] tail;

    logic             active;
    logic             do_alloc;
    logic             do_res;
    logic             do_commit;

    // Handshake decode; everything is computed from registered state only, so
    // a branch resolved this cycle cannot retire until the next one.
    always_comb begin
        active       = rdy && !Clear_flag;
        alloc_ready  = (count < FULL_CNT);
        alloc_tag    = tail;
        commit_ready = (count != '0) && (ent_state[head] == ST_RESOLVED);
        do_alloc     = active && alloc_valid && alloc_ready;
        do_res       = active && res_valid && (ent_state[res_tag] == ST_PENDING);
        do_commit    = active && commit_valid && commit_ready;
    end

    // Entry storage: write on alloc, mark on resolve, free on commit, wipe on flush.
    // The three targets never coincide: the tail is FREE, the resolve target is
    // PENDING and the committed head is RESOLVED.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                ent_id[i]    <= '0;
                ent_pred[i]  <= 1'b0;
                ent_taken[i] <= 1'b0;
                ent_state[i] <= ST_FREE;
            end
        end else if (rdy) begin
            if (Clear_flag) begin
                for (int i = 0; i < DEPTH; i++) begin
                    ent_state[i] <= ST_FREE;
                end
            end else begin
                if (do_alloc) begin
                    ent_id[tail]    <= alloc_bht_id;
                    ent_pred[tail]  <= alloc_pred;
                    ent_taken[tail] <= 1'b0;
                    ent_state[tail] <= ST_PENDING;
                end
                if (do_res) begin
                    ent_taken[res_tag] <= res_taken;
                    ent_state[res_tag] <= ST_RESOLVED;
                end
                if (do_commit) begin
                    ent_state[head] <= ST_FREE;
                end
            end
        end
    end

    // Pointers and occupancy; the count is net-updated when alloc and commit coincide.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (rdy) begin
            if (Clear_flag) begin
                head  <= '0;
                tail  <= '0;
                count <= '0;
            end else begin
                if (do_alloc) begin
                    tail <= tail + 1'b1;
                end
                if (do_commit) begin
                    head <= head + 1'b1;
                end
                case ({do_alloc, do_commit})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: count <= count;
                endcase
            end
        end
    end

    // One-cycle BHT update pulses following each commit; the index holds otherwise.
    // do_commit already excludes stall and flush, so those cycles drop the pulses.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ROB_to_BHT_needchange  <= 1'b0;
            ROB_to_BHT_needchange2 <= 1'b0;
            bht_id2                <= '0;
        end else begin
            ROB_to_BHT_needchange  <= do_commit && (ent_pred[head] != ent_taken[head]);
            ROB_to_BHT_needchange2 <= do_commit && (ent_pred[head] == ent_taken[head]);
            if (do_commit) begin
                bht_id2 <= ent_id[head];
            end
        end
    end

    assign mispredict = ROB_to_BHT_needchange;

endmodule

`default_nettype wire

// File: tb/tb_branch_commit.sv
//==============================================================================
// Module      : tb_branch_commit
// Description : Self-checking bench for branch_commit: directed scenarios and
//               randomized traffic compared against a queue-based model.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_branch_commit;

    localparam int DEPTH = 16;
    localparam int TAG_W = 4;
    localparam int BHT_W = 8;

    logic             clk;
    logic             rst_n;
    logic             rdy;
    logic             clear;
    logic             alloc_valid;
    logic [BHT_W-1:0] alloc_bht_id;
    logic             alloc_pred;
    logic             alloc_ready;
    logic [TAG_W-1:0] alloc_tag;
    logic             res_valid;
    logic [TAG_W-1:0] res_tag;
    logic             res_taken;
    logic             commit_valid;
    logic             commit_ready;
    logic             needchange;
    logic             needchange2;
    logic [BHT_W-1:0] bht_id2;
    logic             mispredict;
    logic [TAG_W:0]   count;

    branch_commit #(.DEPTH(DEPTH), .TAG_W(TAG_W), .BHT_W(BHT_W)) dut (
        .clk                    (clk),
        .rst                    (rst_n),
        .rdy                    (rdy),
        .Clear_flag             (clear),
        .alloc_valid            (alloc_valid),
        .alloc_bht_id           (alloc_bht_id),
        .alloc_pred             (alloc_pred),
        .alloc_ready            (alloc_ready),
        .alloc_tag              (alloc_tag),
        .res_valid              (res_valid),
        .res_tag                (res_tag),
        .res_taken              (res_taken),
        .commit_valid           (commit_valid),
        .commit_ready           (commit_ready),
        .ROB_to_BHT_needchange  (needchange),
        .ROB_to_BHT_needchange2 (needchange2),
        .bht_id2                (bht_id2),
        .mispredict             (mispredict),
        .count                  (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: in-flight branches as an ordered queue with their tags.
    typedef struct {
        int tag;
        int id;
        bit pred;
        bit taken;
        bit resolved;
    } ent_t;

    ent_t q[$];
    int   m_tail;
    bit   m_nc;
    bit   m_nc2;
    int   m_bid;

    int n_checks;
    int n_fail;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit m_commit_ready();
        return (q.size() > 0) && q[0].resolved;
    endfunction

    task automatic model_reset();
        q.delete();
        m_tail = 0;
        m_nc   = 0;
        m_nc2  = 0;
        m_bid  = 0;
    endtask

    task automatic check_outputs();
        chk("count",       32'(count),        32'(q.size()));
        chk("alloc_ready", 32'(alloc_ready),  32'(q.size() < DEPTH));
        chk("alloc_tag",   32'(alloc_tag),    32'(m_tail));
        chk("commit_rdy",  32'(commit_ready), 32'(m_commit_ready()));
        chk("needchange",  32'(needchange),   32'(m_nc));
        chk("needchange2", 32'(needchange2),  32'(m_nc2));
        chk("mispredict",  32'(mispredict),   32'(m_nc));
        chk("bht_id2",     32'(bht_id2),      32'(m_bid));
    endtask

    task automatic idle_inputs();
        rdy          = 1'b1;
        clear        = 1'b0;
        alloc_valid  = 1'b0;
        alloc_bht_id = '0;
        alloc_pred   = 1'b0;
        res_valid    = 1'b0;
        res_tag      = '0;
        res_taken    = 1'b0;
        commit_valid = 1'b0;
    endtask

    // Advance the model by one clock using the currently driven inputs.
    task automatic model_step();
        bit   do_commit;
        bit   do_alloc;
        ent_t e;
        m_nc  = 0;
        m_nc2 = 0;
        if (!rdy) return;
        if (clear) begin
            q.delete();
            m_tail = 0;
            return;
        end
        do_commit = commit_valid && m_commit_ready();
        do_alloc  = alloc_valid && (q.size() < DEPTH);
        if (res_valid) begin
            foreach (q[i]) begin
                if (q[i].tag == int'(res_tag) && !q[i].resolved) begin
                    q[i].taken    = res_taken;
                    q[i].resolved = 1;
                end
            end
        end
        if (do_commit) begin
            e     = q.pop_front();
            m_nc  = (e.pred != e.taken);
            m_nc2 = (e.pred == e.taken);
            m_bid = e.id;
        end
        if (do_alloc) begin
            e.tag      = m_tail;
            e.id       = int'(alloc_bht_id);
            e.pred     = alloc_pred;
            e.taken    = 0;
            e.resolved = 0;
            q.push_back(e);
            m_tail = (m_tail + 1) % DEPTH;
        end
    endtask

    // Called just after a falling edge: model the coming edge, clock, check, go idle.
    task automatic step();
        model_step();
        @(posedge clk);
        @(negedge clk);
        check_outputs();
        idle_inputs();
    endtask

    task automatic do_alloc(input int id, input bit pred);
        alloc_valid  = 1'b1;
        alloc_bht_id = id[BHT_W-1:0];
        alloc_pred   = pred;
        step();
    endtask

    task automatic do_resolve(input int tag, input bit taken);
        res_valid = 1'b1;
        res_tag   = tag[TAG_W-1:0];
        res_taken = taken;
        step();
    endtask

    task automatic do_commit();
        commit_valid = 1'b1;
        step();
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        idle_inputs();
        model_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check_outputs();
        chk("rst_alloc_ready", 32'(alloc_ready), 32'd1);
        chk("rst_commit_ready", 32'(commit_ready), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check_outputs();

        // Correct prediction retires with needchange2
        do_alloc(8'h12, 1'b1);
        do_resolve(0, 1'b1);
        do_commit();
        chk("t1_nc2", 32'(needchange2), 32'd1);
        chk("t1_nc", 32'(needchange), 32'd0);
        chk("t1_bid", 32'(bht_id2), 32'h12);
        chk("t1_cnt", 32'(count), 32'd0);
        step();
        chk("t1_nc2_drop", 32'(needchange2), 32'd0);

        // Misprediction pulses for exactly one cycle
        do_alloc(8'h05, 1'b0);
        do_resolve(1, 1'b1);
        do_commit();
        chk("t2_mis", 32'(mispredict), 32'd1);
        chk("t2_bid", 32'(bht_id2), 32'h05);
        step();
        chk("t2_mis_drop", 32'(mispredict), 32'd0);
        chk("t2_bid_hold", 32'(bht_id2), 32'h05);

        // Fill to full, commit while alloc is attempted, then wrap-around alloc
        clear = 1'b1;
        step();
        for (int i = 0; i < DEPTH; i++) do_alloc(8'h40 + i, i[0]);
        chk("t3_full_rdy", 32'(alloc_ready), 32'd0);
        chk("t3_full_cnt", 32'(count), 32'd16);
        do_resolve(0, 1'b0);
        commit_valid = 1'b1;
        alloc_valid  = 1'b1;
        alloc_bht_id = 8'h99;
        step();
        chk("t3_cnt15", 32'(count), 32'd15);
        chk("t3_tag0", 32'(alloc_tag), 32'd0);
        do_alloc(8'h77, 1'b1);
        chk("t3_cnt16", 32'(count), 32'd16);

        // Out-of-order resolution, in-order retirement
        clear = 1'b1;
        step();
        for (int i = 0; i < 3; i++) do_alloc(8'h20 + i, 1'b1);
        commit_valid = 1'b1; res_valid = 1'b1; res_tag = 4'd1; res_taken = 1'b1;
        step();
        commit_valid = 1'b1; res_valid = 1'b1; res_tag = 4'd2; res_taken = 1'b0;
        step();
        chk("t4_blocked", 32'(commit_ready), 32'd0);
        commit_valid = 1'b1; res_valid = 1'b1; res_tag = 4'd0; res_taken = 1'b1;
        step();
        for (int i = 0; i < 3; i++) begin
            commit_valid = 1'b1;
            step();
            chk("t4_order", 32'(bht_id2), 32'h20 + 32'(i));
        end
        chk("t4_empty", 32'(count), 32'd0);

        // Flush beats a simultaneous commit; stale resolve is ignored
        for (int i = 0; i < 3; i++) do_alloc(8'h30 + i, 1'b0);
        for (int i = 0; i < 3; i++) do_resolve((3 + i) % DEPTH, 1'b0);
        commit_valid = 1'b1;
        clear        = 1'b1;
        step();
        chk("t5_nopulse", 32'(needchange2), 32'd0);
        chk("t5_cnt", 32'(count), 32'd0);
        do_resolve(0, 1'b1);
        chk("t5_stale", 32'(commit_ready), 32'd0);

        // Stall after commit: pulse lasts one cycle, stalled alloc is dropped
        do_alloc(8'h55, 1'b1);
        do_resolve(0, 1'b1);
        do_commit();
        for (int i = 0; i < 3; i++) begin
            rdy         = 1'b0;
            alloc_valid = 1'b1;
            step();
            chk("t6_nopulse", 32'(needchange2), 32'd0);
        end
        chk("t6_cnt", 32'(count), 32'd0);

        // Same-cycle resolve of the entry being allocated is ignored
        alloc_valid = 1'b1; alloc_bht_id = 8'h66;
        res_valid = 1'b1; res_tag = alloc_tag; res_taken = 1'b1;
        step();
        chk("t7_pending", 32'(commit_ready), 32'd0);

        // Asynchronous reset mid-operation
        do_resolve(1, 1'b1);
        commit_valid = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs();
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        check_outputs();
        idle_inputs();

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            rdy          = ($urandom_range(0, 9) != 0);
            clear        = ($urandom_range(0, 79) == 0);
            alloc_valid  = ($urandom_range(0, 1) == 1);
            alloc_bht_id = BHT_W'($urandom);
            alloc_pred   = $urandom_range(0, 1) == 1;
            res_valid    = ($urandom_range(0, 9) < 6);
            if (q.size() > 0 && $urandom_range(0, 3) != 0)
                res_tag = TAG_W'(q[$urandom_range(0, q.size() - 1)].tag);
            else
                res_tag = TAG_W'($urandom);
            res_taken    = $urandom_range(0, 1) == 1;
            commit_valid = ($urandom_range(0, 9) < ((n / 500) % 2 == 0 ? 3 : 7));
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
